// File: rtl/imm_pkg.sv
// Shared constants for the immediate-table controller: table geometry,
// the default immediate set loaded after every reset, and controller states.
package imm_pkg;
  localparam int IDX_W  = 5;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] DEFAULT_IMM [2**IDX_W] = '{
    8'd61,  8'd62,  8'd63,  8'd0,   8'd64,  8'd128, 8'd10,  8'd26,
    8'd32,  8'd1,   8'd127, 8'd75,  8'd65,  8'd74,  8'd73,  8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255
  };

  typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/imm_arb.sv
// Two-requester arbiter for the table read port: core has fixed priority,
// debug ages while denied and is forced through once it has waited MAX_WAIT cycles.
module imm_arb #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic core_req_i,
  input  logic dbg_req_i,
  output logic core_gnt_o,
  output logic dbg_gnt_o
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              aged;

  always_comb begin
    aged       = (wait_q == WAIT_LIM);
    dbg_gnt_o  = en_i && dbg_req_i && (!core_req_i || aged);
    core_gnt_o = en_i && core_req_i && !dbg_gnt_o;
    wait_d     = wait_q;
    // Requests made while the port is disabled are ignored, so they do not age.
    if (!en_i || !dbg_req_i || dbg_gnt_o) begin
      wait_d = '0;
    end else if (!aged) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
endmodule

// File: rtl/imm_table_ctrl.sv
// Immediate table controller: loads the default immediates after reset, then
// serves one arbitrated read per cycle (core/debug) and accepts config rewrites.
module imm_table_ctrl #(
  parameter int IDX_W    = imm_pkg::IDX_W,
  parameter int DATA_W   = imm_pkg::DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic [IDX_W-1:0]  core_idx_i,
  output logic              core_gnt_o,
  input  logic              dbg_req_i,
  input  logic [IDX_W-1:0]  dbg_idx_i,
  output logic              dbg_gnt_o,
  output logic              rd_valid_o,
  output logic              rd_src_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              cfg_valid_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  output logic              cfg_ready_o,
  output logic              init_done_o
);
  import imm_pkg::*;

  localparam int DEPTH = 2**IDX_W;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               port_en;
  logic               any_gnt;
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_valid_q, rd_src_q;
  logic [DATA_W-1:0]  rd_data_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (&init_cnt_q) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Gating with reset keeps grants and cfg_ready low for the whole reset cycle.
  assign port_en     = (state_q == RUN) && !rst_i;
  assign cfg_ready_o = port_en;
  assign init_done_o = (state_q == RUN);

  imm_arb #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (port_en),
    .core_req_i (core_req_i),
    .dbg_req_i  (dbg_req_i),
    .core_gnt_o (core_gnt_o),
    .dbg_gnt_o  (dbg_gnt_o)
  );

  assign any_gnt = core_gnt_o || dbg_gnt_o;
  assign rd_idx  = dbg_gnt_o ? dbg_idx_i : core_idx_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == INIT) begin
        mem_q[init_cnt_q] <= DATA_W'(DEFAULT_IMM[init_cnt_q]);
      end else if (cfg_valid_i && cfg_ready_o) begin
        mem_q[cfg_idx_i] <= cfg_data_i;
      end
    end
  end

  // Read stage: table sampled before a same-edge write lands, so it returns the old value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_src_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= any_gnt;
      if (any_gnt) begin
        rd_src_q  <= dbg_gnt_o;
        rd_data_q <= mem_q[rd_idx];
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_src_o   = rd_src_q;
  assign rd_data_o  = rd_data_q;
endmodule

// File: doc/imm_table_ctrl.md
# imm_table_ctrl

Programmable immediate-table controller for the single-cycle core. Holds a 32-entry × 8-bit immediate table, initialises it from the team's default immediate set after reset, and arbitrates one shared read port between the core decode stage and the debug port. It also accepts runtime rewrites of entries through a valid/ready config port. Sits between the instruction decoder (5-bit immediate index) and the ALU operand mux.

## Interface
- IDX_W, 5, index width; table depth is 2**IDX_W
- DATA_W, 8, immediate width
- MAX_WAIT, 4, cycles a debug request may be denied before it is forced to win
- Clk  in  1  clock; all logic on rising edge
- Reset  in  1  reset; synchronous, active-high
- core_req  in  1  core read request
- core_idx  in  IDX_W  core read index
- core_gnt  out  1  core read granted this cycle (combinational)
- dbg_req  in  1  debug read request
- dbg_idx  in  IDX_W  debug read index
- dbg_gnt  out  1  debug read granted this cycle (combinational)
- rd_valid  out  1  rd_data valid (registered)
- rd_src  out  1  owner of rd_data: 0 core, 1 debug
- rd_data  out  DATA_W  read result
- cfg_valid  in  1  config write valid
- cfg_idx  in  IDX_W  config write index
- cfg_data  in  DATA_W  config write data
- cfg_ready  out  1  config write accepted when high with cfg_valid
- init_done  out  1  table initialised, reads and writes enabled

## Operation
- States: INIT, RUN. Reset forces INIT with init counter = 0 from any state.
- INIT: each cycle writes DEFAULT_IMM[cnt] to entry cnt, then cnt+1. After the entry 31 write, go to RUN. No grants; cfg_ready = 0.
- DEFAULT_IMM: entries 0–14 = 61, 62, 63, 0, 64, 128, 10, 26, 32, 1, 127, 75, 65, 74, 73. Entries 15–31 = 255.
- RUN arbitration, at most one grant per cycle:
  - Core wins by default.
  - Debug wins when dbg_req and no core_req, or when wait_cnt == MAX_WAIT.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on each cycle with dbg_req && !dbg_gnt.
  - Clears on dbg_gnt or on !dbg_req.
  - Cleared by Reset.
- Granted read: rd_data = table[idx], rd_src = winner, rd_valid = 1 on the next cycle. With no grant, rd_valid = 0 next cycle and rd_data/rd_src hold.
- Config: cfg_ready = 1 throughout RUN. Write commits at the edge where cfg_valid && cfg_ready.
- Same-cycle read and write to the same index: read returns the old value. A read in the following cycle returns the new value.
- Reset mid-operation: any write in progress is dropped, rd_valid clears, and the table is fully re-initialised to defaults. Runtime writes are lost.

## Timing
- Reset values: core_gnt 0, dbg_gnt 0, rd_valid 0, rd_src 0, rd_data 0, cfg_ready 0, init_done 0, wait_cnt 0.
- init_done rises 32 edges after the first edge with Reset low and stays high until the next Reset.
- Grant to rd_valid latency: 1 cycle. Sustained throughput: one read per cycle.
- Worst-case debug latency under continuous core_req: MAX_WAIT + 1 cycles from request to grant.
- Requests while !init_done are ignored, not queued. Requesters must hold req until they see gnt.

## Structure
- Package imm_pkg contains:
  - IDX_W, DATA_W
  - DEFAULT_IMM constant array
  - state_t enum {INIT, RUN}
- Sub-module imm_arb: 2-requester fixed-priority arbiter with aging counter (inputs core_req, dbg_req, en; outputs core_gnt, dbg_gnt). Table storage, init counter and read register stay in imm_table_ctrl.

## Test plan
- Reset, then wait for init_done; read every index via core -> rd_data matches DEFAULT_IMM (idx 5 -> 128, idx 20 -> 255), init_done high exactly 32 cycles after Reset falls.
- core_req and dbg_req held together in RUN, MAX_WAIT=4 -> grant pattern C,C,C,C,D repeating; rd_src follows one cycle later.
- cfg write idx 3 = 0x5A with a core read of idx 3 in the same cycle -> read returns 0; read on the next cycle returns 0x5A.
- Requests and cfg_valid during INIT -> no gnt, cfg_ready 0, rd_valid 0, table unchanged.
- Write idx 9 = 7, then assert Reset for one cycle mid-burst -> rd_valid drops, re-init occurs, and idx 9 reads 1 after init_done.
